// File: rtl/writeback_arbiter_pkg.sv
// Shared writeback types and sizing helpers.
// Default widths plus the result record reused by writeback consumers.
package writeback_arbiter_pkg;

  localparam int WB_UNITS  = 4;
  localparam int SEQ_BITS  = 5;
  localparam int PREG_BITS = 6;
  localparam int AREG_BITS = 5;
  localparam int DATA_BITS = 32;

  typedef struct packed {
    logic [DATA_BITS-1:0] pc;
    logic [SEQ_BITS-1:0]  seq_num;
    logic [AREG_BITS-1:0] waddr;
    logic [PREG_BITS-1:0] preg;
    logic [PREG_BITS-1:0] ppreg;
    logic [DATA_BITS-1:0] wdata;
    logic                 wen;
  } wb_entry_t;

  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/x_w_intf.sv
// X->W result interface: execute unit drives val + payload, writeback drives rdy.
// Ports: val, rdy, pc, seq_num, waddr, preg, ppreg, wdata, wen.
interface X__WIntf #(
  parameter int p_seq_num_bits   = 5,
  parameter int p_phys_addr_bits = 6
);
  logic                        val;
  logic                        rdy;
  logic [31:0]                 pc;
  logic [p_seq_num_bits-1:0]   seq_num;
  logic [4:0]                  waddr;
  logic [p_phys_addr_bits-1:0] preg;
  logic [p_phys_addr_bits-1:0] ppreg;
  logic [31:0]                 wdata;
  logic                        wen;

  modport X_intf (
    output val, pc, seq_num, waddr,
    output preg, ppreg, wdata, wen,
    input  rdy
  );

  modport W_intf (
    input  val, pc, seq_num, waddr,
    input  preg, ppreg, wdata, wen,
    output rdy
  );
endinterface

// File: rtl/writeback_arbiter_rr.sv
// Round-robin arbiter: grants first requester at or after ptr.
// Ports: clk, rst (async low), req, advance -> grant index, gnt_val.
module rr_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter  int p_num_reqs = 4,
  localparam int IW = idx_bits(p_num_reqs)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [p_num_reqs-1:0] req,
  input  logic                  advance,
  output logic [IW-1:0]         grant,
  output logic                  gnt_val
);

  logic [IW-1:0] ptr;

  always_comb begin
    int   idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    grant = '0;
    for (int k = 0; k < p_num_reqs; k++) begin
      idx = (int'(ptr) + k) % p_num_reqs;
      if (!found && req[idx]) begin
        grant = IW'(idx);
        found = 1'b1;
      end
    end
  end

  assign gnt_val = |req;

  // explicit wrap keeps non-power-of-2 counts in range
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (advance) begin
      if (grant == IW'(p_num_reqs - 1))
        ptr <= '0;
      else
        ptr <= grant + IW'(1);
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Merges execute-unit results onto one RF write port and commit stream.
// Ports: clk, rst (async low), Ex[] results, rf_* write, C_* commit record.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int p_num_units      = WB_UNITS,
  parameter int p_seq_num_bits   = SEQ_BITS,
  parameter int p_phys_addr_bits = PREG_BITS
) (
  input  logic                        clk,
  input  logic                        rst,
  X__WIntf.W_intf                     Ex [p_num_units],
  output logic                        rf_wen,
  output logic [p_phys_addr_bits-1:0] rf_preg,
  output logic [31:0]                 rf_wdata,
  output logic                        C_val,
  input  logic                        C_rdy,
  output logic [31:0]                 C_pc,
  output logic [p_seq_num_bits-1:0]   C_seq_num,
  output logic [4:0]                  C_waddr,
  output logic [p_phys_addr_bits-1:0] C_preg,
  output logic [p_phys_addr_bits-1:0] C_ppreg,
  output logic                        C_wen
);

  localparam int IW = idx_bits(p_num_units);

  typedef struct packed {
    logic [31:0]                 pc;
    logic [p_seq_num_bits-1:0]   seq_num;
    logic [4:0]                  waddr;
    logic [p_phys_addr_bits-1:0] preg;
    logic [p_phys_addr_bits-1:0] ppreg;
    logic [31:0]                 wdata;
    logic                        wen;
  } entry_t;

  logic [p_num_units-1:0] req;
  entry_t                 ents [p_num_units];
  logic [IW-1:0]          grant;
  logic                   gnt_val;
  logic                   can_accept;
  logic                   in_xfer;
  logic                   out_val;
  entry_t                 out_q;

  assign can_accept = !out_val | (C_val & C_rdy);
  assign in_xfer    = can_accept & gnt_val;

  for (genvar i = 0; i < p_num_units; i++) begin : g_unit
    assign req[i]  = Ex[i].val;
    assign ents[i] = '{
      pc:      Ex[i].pc,
      seq_num: Ex[i].seq_num,
      waddr:   Ex[i].waddr,
      preg:    Ex[i].preg,
      ppreg:   Ex[i].ppreg,
      wdata:   Ex[i].wdata,
      wen:     Ex[i].wen
    };
    // rdy sees only vals, out_val, C_rdy and ptr
    assign Ex[i].rdy = in_xfer & (grant == IW'(i));
  end

  rr_arbiter #(
    .p_num_reqs (p_num_units)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (in_xfer),
    .grant   (grant),
    .gnt_val (gnt_val)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_val <= 1'b0;
      out_q   <= '0;
    end else if (in_xfer) begin
      out_val <= 1'b1;
      out_q   <= ents[grant];
    end else if (C_val & C_rdy) begin
      out_val <= 1'b0;
    end
  end

  assign C_val     = out_val;
  assign C_pc      = out_q.pc;
  assign C_seq_num = out_q.seq_num;
  assign C_waddr   = out_q.waddr;
  assign C_preg    = out_q.preg;
  assign C_ppreg   = out_q.ppreg;
  assign C_wen     = out_q.wen;

  // RF write lands only when the commit record is taken
  assign rf_wen   = C_val & C_rdy & out_q.wen;
  assign rf_preg  = out_q.preg;
  assign rf_wdata = out_q.wdata;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboard bench for writeback_arbiter.
// Per-unit source queues feed Ex; a round-robin model predicts rdy and commits.
module tb_writeback_arbiter;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  seq;
    logic [4:0]  waddr;
    logic [5:0]  preg;
    logic [5:0]  ppreg;
    logic [31:0] wdata;
    logic        wen;
  } rec_t;

  logic        clk;
  logic        rst;
  logic        rf_wen;
  logic [5:0]  rf_preg;
  logic [31:0] rf_wdata;
  logic        C_val;
  logic        C_rdy;
  logic [31:0] C_pc;
  logic [4:0]  C_seq_num;
  logic [4:0]  C_waddr;
  logic [5:0]  C_preg;
  logic [5:0]  C_ppreg;
  logic        C_wen;

  logic [3:0] d_val;
  rec_t       d_rec [4];
  logic [3:0] got_rdy;

  rec_t src_q [4][$];
  rec_t sb [$];
  int   m_ptr;
  bit   m_full;
  int   n_checks;
  int   n_fail;

  X__WIntf #(.p_seq_num_bits(5), .p_phys_addr_bits(6)) ex [4] ();

  for (genvar g = 0; g < 4; g++) begin : g_drv
    assign ex[g].val     = d_val[g];
    assign ex[g].pc      = d_rec[g].pc;
    assign ex[g].seq_num = d_rec[g].seq;
    assign ex[g].waddr   = d_rec[g].waddr;
    assign ex[g].preg    = d_rec[g].preg;
    assign ex[g].ppreg   = d_rec[g].ppreg;
    assign ex[g].wdata   = d_rec[g].wdata;
    assign ex[g].wen     = d_rec[g].wen;
    assign got_rdy[g]    = ex[g].rdy;
  end

  writeback_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .Ex        (ex),
    .rf_wen    (rf_wen),
    .rf_preg   (rf_preg),
    .rf_wdata  (rf_wdata),
    .C_val     (C_val),
    .C_rdy     (C_rdy),
    .C_pc      (C_pc),
    .C_seq_num (C_seq_num),
    .C_waddr   (C_waddr),
    .C_preg    (C_preg),
    .C_ppreg   (C_ppreg),
    .C_wen     (C_wen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic present();
    for (int i = 0; i < 4; i++) begin
      d_val[i] = (src_q[i].size() > 0);
      d_rec[i] = (src_q[i].size() > 0) ? src_q[i][0] : '0;
    end
  endtask

  task automatic push(input int u, input logic [4:0] seq,
                      input logic [5:0] preg, input logic [31:0] wdata,
                      input logic wen);
    rec_t r;
    r.pc    = 32'h1000 + {27'd0, seq} * 4;
    r.seq   = seq;
    r.waddr = seq ^ 5'h0a;
    r.preg  = preg;
    r.ppreg = preg + 6'd1;
    r.wdata = wdata;
    r.wen   = wen;
    src_q[u].push_back(r);
  endtask

  function automatic int model_grant(input logic [3:0] v);
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (m_ptr + k) % 4;
      if (v[idx]) return idx;
    end
    return 0;
  endfunction

  task automatic cycle();
    logic [3:0] ev;
    bit   any;
    bit   can;
    int   g;
    int   xfer;
    rec_t h;
    @(negedge clk);
    ev  = d_val;
    any = |ev;
    can = !m_full || C_rdy;
    g   = model_grant(ev);
    chk("ptr", 64'(dut.u_arb.ptr), 64'(m_ptr));
    chk("rdy", 64'(got_rdy), (can && any) ? 64'(4'b1 << g) : 64'd0);
    chk("c_val", 64'(C_val), 64'(m_full));
    if (m_full) begin
      h = sb[0];
      chk("c_seq", 64'(C_seq_num), 64'(h.seq));
      chk("c_pc", 64'(C_pc), 64'(h.pc));
      chk("c_waddr", 64'(C_waddr), 64'(h.waddr));
      chk("c_preg", 64'(C_preg), 64'(h.preg));
      chk("c_ppreg", 64'(C_ppreg), 64'(h.ppreg));
      chk("c_wen", 64'(C_wen), 64'(h.wen));
      chk("rf_preg", 64'(rf_preg), 64'(h.preg));
      chk("rf_wdata", 64'(rf_wdata), 64'(h.wdata));
      chk("rf_wen", 64'(rf_wen), 64'(C_rdy & h.wen));
      if (C_rdy) void'(sb.pop_front());
    end else begin
      chk("rf_wen_idle", 64'(rf_wen), 64'd0);
    end
    xfer = -1;
    if (can && any) begin
      sb.push_back(src_q[g][0]);
      m_full = 1'b1;
      m_ptr  = (g + 1) % 4;
      xfer   = g;
    end else if (m_full && C_rdy) begin
      m_full = 1'b0;
    end
    @(posedge clk);
    #1;
    if (xfer >= 0) void'(src_q[xfer].pop_front());
    present();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_ptr    = 0;
    m_full   = 1'b0;
    rst      = 1'b0;
    C_rdy    = 1'b0;
    present();
    #12;
    chk("rst_c_val", 64'(C_val), 64'd0);
    chk("rst_rf_wen", 64'(rf_wen), 64'd0);
    chk("rst_rdy", 64'(got_rdy), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) cycle();

    // single result from unit 2
    C_rdy = 1'b1;
    push(2, 5'd5, 6'd12, 32'hDEADBEEF, 1'b1);
    present();
    repeat (3) cycle();

    // all units busy: one commit per cycle
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 3; j++)
        push(i, 5'(8 + i * 3 + j), 6'(20 + i * 3 + j), $urandom, 1'b1);
    present();
    repeat (15) cycle();

    // backpressure while unit 1 waits
    C_rdy = 1'b0;
    push(0, 5'd1, 6'd33, 32'h0BAD_F00D, 1'b1);
    present();
    cycle();
    push(1, 5'd2, 6'd34, 32'h1234_5678, 1'b1);
    present();
    repeat (3) cycle();
    C_rdy = 1'b1;
    repeat (3) cycle();

    // store: commit record without RF write
    push(3, 5'd3, 6'd7, 32'hCAFE_0000, 1'b0);
    present();
    repeat (3) cycle();
    chk("drained", 64'(sb.size()), 64'd0);

    // reset while full and stalled
    C_rdy = 1'b0;
    push(1, 5'd4, 6'd40, 32'h5555_AAAA, 1'b1);
    present();
    repeat (2) cycle();
    #2;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) src_q[i].delete();
    present();
    #1;
    chk("async_c_val", 64'(C_val), 64'd0);
    chk("async_rf_wen", 64'(rf_wen), 64'd0);
    chk("async_rdy", 64'(got_rdy), 64'd0);
    C_rdy = 1'b1;
    #1;
    chk("async_rf_wen_rdy", 64'(rf_wen), 64'd0);
    sb.delete();
    m_full = 1'b0;
    m_ptr  = 0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) cycle();
    push(0, 5'd6, 6'd9, 32'h0000_0042, 1'b1);
    present();
    repeat (3) cycle();
    chk("final_drain", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Merges result streams from `p_num_units` execute units onto one register-file write port and one commit stream, granting at most one unit per cycle. Grant order is round-robin. Sits directly downstream of the execute units, including the load/store unit, on their X→W interfaces. Upstream of the commit/reorder logic. Provides one registered output stage with full-throughput valid/ready flow control.

## Interface
Parameters:
- `p_num_units`, 4, number of execute-unit inputs (≥2)
- `p_seq_num_bits`, 5, sequence-number width
- `p_phys_addr_bits`, 6, physical register index width

Ports:
- `clk`  in  1  clock; all state updates on posedge
- `rst`  in  1  reset; one clock, asynchronous, active-low (0 = reset)
- `Ex[p_num_units]`  X__WIntf.W_intf  —  per-unit result: val, rdy (driven here), pc[32], seq_num, waddr[5], preg, ppreg, wdata[32], wen
- `rf_wen`  out  1  register-file write enable
- `rf_preg`  out  p_phys_addr_bits  register-file write index
- `rf_wdata`  out  32  register-file write data
- `C_val`  out  1  commit record valid
- `C_rdy`  in  1  commit consumer ready
- `C_pc`, `C_seq_num`, `C_waddr`, `C_preg`, `C_ppreg`, `C_wen`  out  —  commit record fields, widths as on Ex

## Operation
- State:
  - output register `out_reg` (val + all fields)
  - round-robin pointer `ptr` [clog2(p_num_units)]
- Arbitration:
  - `grant` = first index i with `Ex[i].val`, scanning `ptr, ptr+1, …` modulo `p_num_units`.
  - `any_val` = OR of all `Ex[i].val`.
- Accept condition: `can_accept = !out_reg.val | (C_val & C_rdy)`.
- Per-unit ready: `Ex[i].rdy = can_accept & any_val & (grant == i)`. At most one `rdy` is high per cycle.
  - An unchosen unit holds val and its payload stable until granted.
- On input transfer (`Ex[grant].val & Ex[grant].rdy`):
  - `out_reg` loads that unit's fields with val=1.
  - `ptr` ← `grant+1` mod `p_num_units`. Wraps from `p_num_units-1` to 0; non-power-of-2 counts wrap explicitly.
- On output transfer with no input transfer: `out_reg.val` ← 0. Other fields are don't-care.
- No transfer: `out_reg` and `ptr` hold.
- Commit outputs: `C_val = out_reg.val`; all other `C_*` fields mirror `out_reg`.
- Register-file write:
  - `rf_wen = C_val & C_rdy & out_reg.wen`
  - `rf_preg = out_reg.preg`
  - `rf_wdata = out_reg.wdata`
  - The physical register is written in the same cycle the commit record is accepted, never earlier. Stores (wen=0) produce a commit record but no RF write.
- No reordering within a unit; across units, order is arbitration order.

## Timing
- Latency: one cycle from input transfer to `C_val` high.
- Throughput: one result per cycle while `C_rdy` stays high. A simultaneous drain and refill of `out_reg` is allowed in the same cycle.
- Reset (asynchronous assert, synchronous deassert assumed upstream):
  - `out_reg.val`=0, `ptr`=0
  - hence `C_val`=0, `rf_wen`=0, all `Ex[i].rdy`=0
  - Fields other than val reset to 0.
- Reset mid-operation: a result held in `out_reg` is discarded without an RF write. Units re-present after reset per their own reset.
- Backpressure:
  - `C_rdy`=0 with `out_reg` full → every `Ex[i].rdy`=0, `ptr` holds.
  - The payload on `C_*` stays stable until accepted.
- `ptr` advances only on an input transfer. A valid-but-unchosen unit keeps its priority slot and is served within `p_num_units` transfers (starvation-free).
- `Ex[i].rdy` is combinational from the `Ex` vals, `out_reg.val`, `C_rdy` and `ptr`. It has no path from any `Ex` payload field.

## Structure
- The per-entry result struct (pc, seq_num, waddr, preg, ppreg, wdata, wen) goes in `UArch` as a shared typedef, parameterised via the widths above. Other writeback consumers reuse it.
- One sub-module: `rr_arbiter`, with `p_num_reqs`, inputs `req[]` and `advance`, outputs `grant` index and `gnt_val`. It owns `ptr`; reusable for memory-port arbitration.
- Linetrace: granted unit index and seq_num per cycle (non-synthesis only).

## Test plan
- After reset, no stimulus → `C_val`=0, `rf_wen`=0, all `Ex[i].rdy`=0, `ptr`=0.
- `Ex[2]` sends seq 5, preg 12, wdata 0xDEADBEEF, wen=1, `C_rdy`=1 → next cycle `C_val`=1, `C_seq_num`=5, `rf_wen`=1, `rf_preg`=12, `rf_wdata`=0xDEADBEEF; `ptr`=3.
- All four units valid continuously, `C_rdy`=1 → grants 0,1,2,3,0,…, one commit per cycle, no bubbles.
- `out_reg` full, `C_rdy`=0 for 3 cycles with `Ex[1]` valid → `Ex[1].rdy`=0, `C_*` stable for 3 cycles; on `C_rdy`=1, drain and `Ex[1]` load in the same cycle.
- Store result (wen=0, preg 7) accepted → `C_val`=1, `C_wen`=0, `rf_wen`=0.
- `rst` asserted low mid-cycle with `out_reg` full and `C_rdy`=0 → `C_val` drops immediately (async), no `rf_wen` pulse, `ptr`=0 after release.
